math_round_ctrl: RTL and testbench

Round sequencer for the binary math game. It generates operand pairs from a seeded LFSR and drives them into the 4-bit adder. It then waits for the player's 4-bit answer or a timeout, grades the answer against the adder's sum, and tracks round count and score. It sits between the player input debounce/pulse logic and the display/score logic, and is the only driver of the adder's operand inputs.

---
 rtl/math_round_ctrl.sv | 104 ++++++++++
 tb/tb_math_round_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/math_round_ctrl.sv
// math_round_ctrl: LFSR-driven operand sequencer for the math game; grades answers
// against the external adder's sum and tracks round count and score.
module math_round_ctrl #(
    parameter int ROUNDS  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seed,
    input  logic       submit,
    input  logic [3:0] answer,
    input  logic [3:0] sum,
    output logic [3:0] first,
    output logic [3:0] second,
    output logic       correct,
    output logic       wrong,
    output logic       timed_out,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RND     = 4'(ROUNDS);

    logic [2:0]  r_state;
    logic [7:0]  r_lfsr;
    logic [15:0] r_timer;
    logic [3:0]  r_ans;
    logic        r_to;
    logic        w_pass;
    logic [3:0]  w_round_nx;
    logic [7:0]  w_seed;
    logic [7:0]  w_lfsr_nx;

    // A zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed     = (seed == 8'h00) ? 8'h01 : seed;
    assign w_lfsr_nx  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_pass     = !r_to && (r_ans == sum);
    assign w_round_nx = round + 4'd1;
    assign busy       = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done       = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= 8'h01;
            r_timer   <= 16'd0;
            r_ans     <= 4'd0;
            r_to      <= 1'b0;
            first     <= 4'd0;
            second    <= 4'd0;
            correct   <= 1'b0;
            wrong     <= 1'b0;
            timed_out <= 1'b0;
            score     <= 4'd0;
            round     <= 4'd0;
        end else begin
            correct   <= 1'b0;
            wrong     <= 1'b0;
            timed_out <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_lfsr  <= w_seed;
                    score   <= 4'd0;
                    round   <= 4'd0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    first   <= r_lfsr[7:4];
                    second  <= r_lfsr[3:0];
                    r_lfsr  <= w_lfsr_nx;
                    r_timer <= 16'd0;
                    r_to    <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (submit) begin
                    r_ans   <= answer;
                    r_state <= S_CHECK;
                end else if (r_timer == TO_LAST) begin
                    r_to    <= 1'b1;
                    r_state <= S_CHECK;
                end else begin
                    r_timer <= r_timer + 16'd1;
                end
                S_CHECK: begin
                    correct   <= w_pass;
                    wrong     <= !w_pass;
                    timed_out <= r_to;
                    if (w_pass) score <= score + 4'd1;
                    round   <= w_round_nx;
                    r_state <= (w_round_nx == RND) ? S_DONE : S_LOAD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_math_round_ctrl.sv
// tb_math_round_ctrl: scoreboard bench for math_round_ctrl with a behavioural adder
// and game model; a negedge monitor grades every result pulse.
module tb_math_round_ctrl;
    localparam int ROUNDS = 2;
    localparam int TO     = 4;

    typedef struct {
        logic [20:0] v;
        int          c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [3:0] answer = 4'd0;
    logic [3:0] sum, first, second, score, round;
    logic       correct, wrong, timed_out, busy, done;
    logic [4:0] w_full;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [7:0] m_lfsr;
    logic [3:0] m_a, m_b, m_score, m_round;

    math_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .submit(submit),
        .answer(answer), .sum(sum), .first(first), .second(second),
        .correct(correct), .wrong(wrong), .timed_out(timed_out),
        .score(score), .round(round), .busy(busy), .done(done)
    );

    // 4-bit adder that reports 0 on overflow
    assign w_full = {1'b0, first} + {1'b0, second};
    assign sum    = w_full[4] ? 4'd0 : w_full[3:0];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [20:0] got;
        exp_t        e;
        if (!rst && (correct || wrong || timed_out)) begin
            got = {correct, wrong, timed_out, done, busy, score, round, first, second};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got=%h cyc=%0d", got, cyc);
            end else begin
                e = q.pop_front();
                if (got !== e.v || cyc != e.c) begin
                    bad++;
                    $display("FAIL round_result got=%h@%0d exp=%h@%0d", got, cyc, e.v, e.c);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    task automatic start_game(input logic [7:0] s);
        start = 1'b1;
        seed  = s;
        tick;
        start   = 1'b0;
        m_lfsr  = (s == 8'h00) ? 8'h01 : s;
        m_score = 4'd0;
        m_round = 4'd0;
    endtask

    // kind: 0 = let it time out, 1 = submit forced, 2 = submit the right answer
    task automatic play_round(input int kind, input int d, input logic [3:0] forced);
        int         s;
        logic [3:0] exp_s, ans;
        logic       pass, to;
        m_a    = m_lfsr[7:4];
        m_b    = m_lfsr[3:0];
        m_lfsr = step(m_lfsr);
        s      = int'(m_a) + int'(m_b);
        exp_s  = (s >= 16) ? 4'd0 : 4'(s);
        ans    = (kind == 2) ? exp_s : forced;
        to     = (kind == 0);
        submit = 1'($urandom_range(0, 1));
        answer = 4'($urandom);
        tick;
        submit = 1'b0;
        repeat (to ? TO : d) begin
            start = ($urandom_range(0, 3) == 0);
            seed  = 8'($urandom);
            tick;
        end
        start = 1'b0;
        if (!to) begin
            submit = 1'b1;
            answer = ans;
            tick;
            submit = 1'b0;
        end
        pass = !to && (ans == exp_s);
        if (pass) m_score++;
        m_round++;
        q.push_back('{v: {pass, !pass, to, m_round == 4'(ROUNDS), m_round != 4'(ROUNDS),
                          m_score, m_round, m_a, m_b}, c: cyc + 1});
        submit = 1'($urandom_range(0, 1));
        answer = 4'($urandom);
        tick;
        submit = 1'b0;
    endtask

    task automatic check_zero(input string n);
        check({n, "_first"}, 32'(first), 0);
        check({n, "_second"}, 32'(second), 0);
        check({n, "_score"}, 32'(score), 0);
        check({n, "_round"}, 32'(round), 0);
        check({n, "_pulses"}, 32'({correct, wrong, timed_out}), 0);
        check({n, "_busy_done"}, 32'({busy, done}), 0);
    endtask

    initial begin
        int k;
        repeat (3) tick;
        check_zero("reset");
        rst = 1'b0;
        tick;
        start_game(8'h35);
        play_round(1, 1, 4'd8);
        play_round(1, 0, 4'd0);
        check("done_after_game", 32'({busy, done}), 32'b01);
        repeat (2) tick;
        start_game(8'h35);
        play_round(2, 2, 4'd0);
        play_round(1, 2, 4'hF);
        start_game(8'hC3);
        play_round(0, 0, 4'd0);
        play_round(2, TO - 1, 4'd0);
        start_game(8'h00);
        play_round(2, 0, 4'd0);
        play_round(2, TO - 1, 4'd0);
        start_game(8'h5A);
        play_round(2, 1, 4'd0);
        tick;
        tick;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        #2 rst = 1'b0;
        tick;
        submit = 1'b1;
        answer = 4'($urandom);
        tick;
        submit = 1'b0;
        repeat (3) tick;
        check("idle_after_reset", 32'({busy, done, score, round}), 0);
        repeat (30) begin
            start_game(8'($urandom));
            repeat (ROUNDS) begin
                k = int'($urandom_range(0, 3));
                play_round((k == 0) ? 0 : ((k == 1) ? 1 : 2), int'($urandom_range(0, TO - 1)), 4'($urandom));
            end
            repeat ($urandom_range(0, 3)) begin
                submit = 1'($urandom_range(0, 1));
                answer = 4'($urandom);
                tick;
            end
            submit = 1'b0;
        end
        repeat (3) tick;
        check("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
